// File: rtl/register_file_pkg.sv
// Shared datapath width constants for the core, including the register file geometry.
package register_file_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int RF_DATA_WIDTH  = XLEN_DEF;
    localparam int RF_ADDR_WIDTH  = 5;
    localparam int RF_NUM_REGS    = 2 ** RF_ADDR_WIDTH;
    localparam int IMM_WIDTH      = 12;
    localparam int SHAMT_WIDTH    = 5;

    // Register index 0 is hardwired to zero in the architectural register file.
    function automatic logic is_zero_reg(input logic [RF_ADDR_WIDTH-1:0] idx);
        return (idx == '0);
    endfunction

endpackage

// File: rtl/register_file.sv
// Three-port register file: two combinational read ports and one synchronous write
// port, with register 0 hardwired to zero and a synchronous clear.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WriteEnable3,
    input  logic [ADDR_WIDTH-1:0] Address1,
    input  logic [ADDR_WIDTH-1:0] Address2,
    input  logic [ADDR_WIDTH-1:0] Address3,
    input  logic [DATA_WIDTH-1:0] WD3,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                  wr_en_d;

    assign wr_en_d = WriteEnable3 && (Address3 != '0);

    // Reset takes priority over any write presented on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_d) begin
            regs_q[Address3] <= WD3;
        end
    end

    // Reads are masked at index 0 so the zero register holds even before the first reset.
    assign RD1 = (Address1 == '0) ? '0 : regs_q[Address1];
    assign RD2 = (Address2 == '0) ? '0 : regs_q[Address2];

endmodule

// File: tb/tb_register_file.sv
// Randomized scoreboard bench for register_file against an array-based reference model.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        WriteEnable3;
    logic [4:0]  Address1;
    logic [4:0]  Address2;
    logic [4:0]  Address3;
    logic [31:0] WD3;
    logic [31:0] RD1;
    logic [31:0] RD2;

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .WriteEnable3 (WriteEnable3),
        .Address1     (Address1),
        .Address2     (Address2),
        .Address3     (Address3),
        .WD3          (WD3),
        .RD1          (RD1),
        .RD2          (RD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [32];
    int          vectors     = 0;
    int          miscompares = 0;

    // Drive one cycle: record what the reads must show before the edge, then apply
    // the architectural effect of the edge to the model.
    task automatic step(input bit r, input bit we, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] a3,
                        input logic [31:0] wd, input bit chk, input string tag);
        exp_t e;
        rst          = r;
        WriteEnable3 = we;
        Address1     = a1;
        Address2     = a2;
        Address3     = a3;
        WD3          = wd;
        if (chk) begin
            e.rd1 = model[a1];
            e.rd2 = model[a2];
            e.tag = tag;
            sb_q.push_back(e);
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we && a3 != 5'd0) begin
            model[a3] = wd;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            vectors++;
            if (RD1 !== e.rd1 || RD2 !== e.rd2) begin
                miscompares++;
                $display("FAIL %s: RD1=%08h RD2=%08h, expected RD1=%08h RD2=%08h",
                         e.tag, RD1, RD2, e.rd1, e.rd2);
            end else begin
                $display("ok   %s: A1=%0d A2=%0d RD1=%08h RD2=%08h",
                         e.tag, Address1, Address2, RD1, RD2);
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst = 1'b1; WriteEnable3 = 1'b0;
        Address1 = '0; Address2 = '0; Address3 = '0; WD3 = '0;
        @(posedge clk); #1;

        step(1, 0, 0,  5,  0, 32'h0,        0, "reset");
        step(1, 0, 0,  5,  0, 32'h0,        0, "reset");
        step(0, 1, 0,  5,  0, 32'hDEADBEEF, 1, "reset_read");
        step(0, 0, 0,  0,  0, 32'h0,        1, "r0_write_ignored");
        step(0, 1, 5,  10, 5, 32'h12345678, 1, "wr5_same_cycle_old");
        step(0, 1, 5,  10, 10, 32'hABCDEF00, 1, "wr10_same_cycle_old");
        step(0, 0, 5,  10, 15, 32'hFFFFFFFF, 1, "read5_10_we0");
        step(0, 1, 15, 1,  1, 32'h11111111, 1, "r15_unwritten");
        step(0, 1, 1,  31, 31, 32'h31313131, 1, "r1_readback");
        step(0, 1, 31, 10, 5, 32'hCAFEBABE, 1, "r31_readback");
        step(0, 0, 5,  10, 0, 32'h0,        1, "overwrite5");
        step(1, 1, 5,  10, 5, 32'h55555555, 1, "rst_pending_old");
        step(0, 0, 5,  10, 0, 32'h0,        1, "reset_wins");
        step(0, 1, 7,  7,  7, 32'h77777777, 1, "same_addr_pre");
        step(0, 0, 7,  7,  0, 32'h0,        1, "same_addr_post");

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 39) == 0), $urandom_range(0, 1),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), $urandom, 1, "random");
        end
        step(0, 0, 0, 31, 0, 32'h0, 1, "final");

        repeat (4) @(posedge clk);
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each register and data port.
REQ-002 Parameter ADDR_WIDTH, default 5, address width; register count = 2**ADDR_WIDTH (32).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 WriteEnable3  input  1  write enable for write port 3.
REQ-006 Address1  input  ADDR_WIDTH  read port 1 register index.
REQ-007 Address2  input  ADDR_WIDTH  read port 2 register index.
REQ-008 Address3  input  ADDR_WIDTH  write port 3 register index.
REQ-009 WD3  input  DATA_WIDTH  write data for port 3.
REQ-010 RD1  output  DATA_WIDTH  read data, port 1.
REQ-011 RD2  output  DATA_WIDTH  read data, port 2.

Function
REQ-012 Storage SHALL be 32 registers x 32 bits (2**ADDR_WIDTH x DATA_WIDTH).
REQ-013 RD1/RD2 SHALL be combinational: RDn = reg[AddressN], zero-cycle latency from address change.
REQ-014 Both read ports SHALL operate independently and concurrently, including the same address on both ports.
REQ-015 On rising clk with rst=0, WriteEnable3=1, Address3!=0: reg[Address3] <= WD3; visible on reads immediately after that edge.
REQ-016 WriteEnable3=0 SHALL leave all registers unchanged regardless of Address3/WD3.
REQ-017 Register 0 SHALL always read 0; writes to Address3=0 SHALL be ignored.
REQ-018 No write-through bypass: a read of Address3 in the same cycle as its write returns the old value until the edge.
REQ-019 Overwrite of a written register SHALL replace its full value; other registers unaffected.
REQ-020 Out-of-range addresses cannot occur (full decode of ADDR_WIDTH bits).

Reset
REQ-021 On rising clk with rst=1, all registers SHALL become 0; RD1/RD2 SHALL then read 0 for every address.
REQ-022 rst=1 SHALL take priority over a simultaneous write; the write is discarded.
REQ-023 Reset asserted mid-operation SHALL clear all previously written data at the next rising edge; deassertion restores normal writes from the next edge.
REQ-024 No asynchronous path from rst to state; reads between rst assertion and the edge return prior contents.

Structure
REQ-025 DATA_WIDTH and ADDR_WIDTH defaults SHALL live in the shared project package (alongside other datapath width constants); the module SHALL take them as parameters.
REQ-026 Single module, no sub-modules; storage as one register array with write decode and two read muxes.

Verification
REQ-027 rst=1 for 2 edges, read Address1=0, Address2=5 -> RD1=0, RD2=0.
REQ-028 WE=1, Address3=0, WD3=DEADBEEF, one edge; Address1=0 -> RD1=00000000.
REQ-029 Write R5=12345678, then R10=ABCDEF00; Address1=5, Address2=10, WE=0 -> RD1=12345678, RD2=ABCDEF00; WE=0, Address3=15, WD3=FFFFFFFF, edge -> R15 reads 0.
REQ-030 Boundaries: write R1=11111111 and R31=31313131 -> both read back exactly; overwrite R5=CAFEBABE -> RD1=CAFEBABE, R10 unchanged.
REQ-031 With R5/R10 loaded, rst=1 with WE=1, Address3=5, WD3=55555555 for one edge, then rst=0 -> RD1=0, RD2=0 (reset wins).
REQ-032 Same-cycle read of Address3 during write -> old value before edge, WD3 after edge.
